npcg_toggle_pm_arbiter: RTL and testbench
=========================================

# npcg_toggle_pm_arbiter

Single-owner arbiter that shares one primitive-manager (PM) command/write port among the NPCG command-sequencer clients (program, read, erase, status, reset). It sits between the clients and the PM. It locks ownership from a client's start pulse until that client's last-step pulse, muxes the owner's PM signals through, and gives upstream dispatch a single "may issue" indication. It also flags protocol collisions and counts completed operations.

## Interface
- NumberOfWays, 4, width of the target-way one-hot
- NumberOfClients, 4, number of NPCG clients (index 0 = highest priority)

Clock and reset are synchronous and active-high: `iSystemClock`, `iReset`. Client buses are flattened; client k occupies slice [k*w +: w].

- iSystemClock  in  1  clock
- iReset  in  1  synchronous active-high reset
- iClientStart  in  N  per-client start pulse (client's trigger-accepted strobe)
- iClientLastStep  in  N  per-client last-step pulse
- iClientPCommand  in  8N  per-client PM command trigger
- iClientPCommandOption  in  3N  per-client command option
- iClientTargetWay  in  NumberOfWays*N  per-client target way
- iClientNumOfData  in  16N  per-client length
- iClientCASelect  in  N  per-client cmd(0)/addr(1) select
- iClientCAData  in  8N  per-client CA byte
- iClientWriteData  in  32N  per-client write data
- iClientWriteLast, iClientWriteValid  in  N each  per-client write stream
- oClientWriteReady  out  N  iPM_WriteReady routed to owner only
- oPM_PCommand  out  8
- oPM_PCommandOption  out  3
- oPM_TargetWay  out  NumberOfWays
- oPM_NumOfData  out  16
- oPM_CASelect  out  1
- oPM_CAData  out  8
- oPM_WriteData  out  32
- oPM_WriteLast, oPM_WriteValid  out  1 each
- iPM_WriteReady  in  1  PM write-ready
- oCMDAllow  out  1  upstream may present a command this cycle
- oOwner  out  N  one-hot current owner (0 when idle)
- oCollision  out  1  sticky protocol-error flag
- oOpCount  out  16  completed-operation counter

## Operation
States: Idle, Owned.
- Idle: all oPM_* outputs 0, oClientWriteReady 0, oCMDAllow 1. If any iClientStart is set, capture the lowest set index as owner and go to Owned. If more than one bit is set, also set oCollision.
- Owned: oPM_* = owner's slice (combinational mux on the registered owner). oClientWriteReady = iPM_WriteReady at the owner bit only.
- On owner iClientLastStep: oOpCount += 1 (16-bit, wraps FFFF→0000).
  - If a non-owner iClientStart is high in the same cycle, hand over directly: new owner = lowest such index, stay Owned.
  - Otherwise go to Idle.
- oCMDAllow = Idle, or (Owned and owner iClientLastStep).
- iClientStart from any client while Owned and owner LastStep is low: ignored for ownership, sets oCollision.
- iClientStart from the current owner while Owned: also sets oCollision.
- LastStep from a non-owner: ignored, no count.
- oCollision clears only on reset.

## Timing
- Reset values: state Idle, oOwner 0, oCollision 0, oOpCount 0, all oPM_* 0, oClientWriteReady 0, oCMDAllow 1.
- Ownership latency: start in cycle T gives oOwner and the mux valid from T+1. This matches clients issuing their first PM command in the cycle after start.
- Release: the owner's signals are still forwarded in the LastStep cycle. oOwner = 0 from the next cycle, unless a handover occurs.
- Write path is purely combinational: no added latency on data, valid, last, or ready.
- Reset mid-operation drops ownership at the next edge. Outputs are 0 from that edge on; no count is taken.

## Structure
- A shared package holds the state encoding (Idle=1'b0, Owned=1'b1) and a lowest-index-priority-encoder function.
- One sub-module, `npcg_pm_onehot_mux`, is parameterised on width and client count. It is instantiated once per PM field.

## Test plan
- Client 2 start at T, drives PCommand=8'h08 and NumOfData=5 → oOwner=4'b0100 at T+1, oPM_PCommand=8'h08, oPM_NumOfData=5. LastStep at T+20 → oOwner=0 at T+21, oOpCount=1.
- Clients 1 and 3 start in the same cycle from Idle → owner 4'b0010, oCollision=1.
- Owner 0 LastStep in the same cycle as client 3 start → oOwner=4'b1000 next cycle, oOpCount increments, no collision.
- Client 1 start while client 0 owns mid-operation → owner unchanged, oCollision=1, oPM_* still equal client 0's values.
- Owner write burst of 4 words with iPM_WriteReady toggling → oPM_WriteData, valid, and last equal the owner's; only the owner's oClientWriteReady bit follows ready.
- oOpCount preset to 16'hFFFF via 65535 operations (or forced), one more LastStep → 16'h0000. iReset asserted mid-ownership → outputs 0 at the next edge.

Source files
------------

// File: rtl/npcg_toggle_pm_arbiter_pkg.sv
// Shared definitions for the NPCG primitive-manager arbiter: state encoding
// and the lowest-index priority encoder used for ownership capture.
package npcg_toggle_pm_arbiter_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } arb_state_t;

  localparam int MAX_CLIENTS = 32;

  // Isolates the lowest set bit; index 0 carries the highest priority.
  function automatic logic [MAX_CLIENTS-1:0] lowest_onehot(input logic [MAX_CLIENTS-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  function automatic logic multi_hot(input logic [MAX_CLIENTS-1:0] v);
    return |(v & (v - 1'b1));
  endfunction

endpackage

// File: rtl/npcg_pm_onehot_mux.sv
// AND-OR one-hot selector of one W-bit field out of N flattened client slices.
// An all-zero select yields zero, which gives the idle output value for free.
module npcg_pm_onehot_mux #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic [N-1:0]   i_sel,
  input  logic [N*W-1:0] i_data,
  output logic [W-1:0]   o_data
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < N; k++)
      o_data = o_data | (i_data[k*W +: W] & {W{i_sel[k]}});
  end

endmodule

// File: rtl/npcg_toggle_pm_arbiter.sv
// Single-owner arbiter sharing the PM command/write port among NPCG clients.
// Ownership spans start pulse .. last-step pulse, with direct handover.
module npcg_toggle_pm_arbiter
  import npcg_toggle_pm_arbiter_pkg::*;
#(
  parameter int NumberOfWays    = 4,
  parameter int NumberOfClients = 4
) (
  input  logic                                  iSystemClock,
  input  logic                                  iReset,
  input  logic [NumberOfClients-1:0]            iClientStart,
  input  logic [NumberOfClients-1:0]            iClientLastStep,
  input  logic [8*NumberOfClients-1:0]          iClientPCommand,
  input  logic [3*NumberOfClients-1:0]          iClientPCommandOption,
  input  logic [NumberOfWays*NumberOfClients-1:0] iClientTargetWay,
  input  logic [16*NumberOfClients-1:0]         iClientNumOfData,
  input  logic [NumberOfClients-1:0]            iClientCASelect,
  input  logic [8*NumberOfClients-1:0]          iClientCAData,
  input  logic [32*NumberOfClients-1:0]         iClientWriteData,
  input  logic [NumberOfClients-1:0]            iClientWriteLast,
  input  logic [NumberOfClients-1:0]            iClientWriteValid,
  output logic [NumberOfClients-1:0]            oClientWriteReady,
  output logic [7:0]                            oPM_PCommand,
  output logic [2:0]                            oPM_PCommandOption,
  output logic [NumberOfWays-1:0]               oPM_TargetWay,
  output logic [15:0]                           oPM_NumOfData,
  output logic                                  oPM_CASelect,
  output logic [7:0]                            oPM_CAData,
  output logic [31:0]                           oPM_WriteData,
  output logic                                  oPM_WriteLast,
  output logic                                  oPM_WriteValid,
  input  logic                                  iPM_WriteReady,
  output logic                                  oCMDAllow,
  output logic [NumberOfClients-1:0]            oOwner,
  output logic                                  oCollision,
  output logic [15:0]                           oOpCount
);

  localparam int N = NumberOfClients;

  arb_state_t r_state, w_state_nxt;
  logic [N-1:0] r_owner, w_owner_nxt;
  logic         r_collision, w_collision_set;
  logic [15:0]  r_opcount;
  logic         w_count_inc;

  logic [N-1:0] w_other_start;
  logic         w_owner_last;

  assign w_other_start = iClientStart & ~r_owner;
  assign w_owner_last  = (r_state == S_OWNED) && |(iClientLastStep & r_owner);

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_collision_set = 1'b0;
    w_count_inc     = 1'b0;
    oCMDAllow       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        oCMDAllow = 1'b1;
        if (|iClientStart) begin
          w_state_nxt     = S_OWNED;
          w_owner_nxt     = N'(lowest_onehot(MAX_CLIENTS'(iClientStart)));
          w_collision_set = multi_hot(MAX_CLIENTS'(iClientStart));
        end
      end
      S_OWNED: begin
        // A restart from the owner itself is always a protocol error.
        w_collision_set = |(iClientStart & r_owner);
        if (w_owner_last) begin
          oCMDAllow   = 1'b1;
          w_count_inc = 1'b1;
          if (|w_other_start) begin
            w_owner_nxt = N'(lowest_onehot(MAX_CLIENTS'(w_other_start)));
            if (multi_hot(MAX_CLIENTS'(w_other_start)))
              w_collision_set = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_owner_nxt = '0;
          end
        end else if (|iClientStart) begin
          w_collision_set = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_collision <= 1'b0;
      r_opcount   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_collision <= r_collision | w_collision_set;
      if (w_count_inc)
        r_opcount <= r_opcount + 16'd1;
    end
  end

  assign oOwner            = r_owner;
  assign oCollision        = r_collision;
  assign oOpCount          = r_opcount;
  assign oClientWriteReady = r_owner & {N{iPM_WriteReady}};

  npcg_pm_onehot_mux #(.W(8),  .N(N)) u_mux_pcmd (.i_sel(r_owner), .i_data(iClientPCommand),       .o_data(oPM_PCommand));
  npcg_pm_onehot_mux #(.W(3),  .N(N)) u_mux_popt (.i_sel(r_owner), .i_data(iClientPCommandOption), .o_data(oPM_PCommandOption));
  npcg_pm_onehot_mux #(.W(NumberOfWays), .N(N)) u_mux_way (.i_sel(r_owner), .i_data(iClientTargetWay), .o_data(oPM_TargetWay));
  npcg_pm_onehot_mux #(.W(16), .N(N)) u_mux_nod  (.i_sel(r_owner), .i_data(iClientNumOfData),      .o_data(oPM_NumOfData));
  npcg_pm_onehot_mux #(.W(1),  .N(N)) u_mux_cas  (.i_sel(r_owner), .i_data(iClientCASelect),       .o_data(oPM_CASelect));
  npcg_pm_onehot_mux #(.W(8),  .N(N)) u_mux_cad  (.i_sel(r_owner), .i_data(iClientCAData),         .o_data(oPM_CAData));
  npcg_pm_onehot_mux #(.W(32), .N(N)) u_mux_wd   (.i_sel(r_owner), .i_data(iClientWriteData),      .o_data(oPM_WriteData));
  npcg_pm_onehot_mux #(.W(1),  .N(N)) u_mux_wl   (.i_sel(r_owner), .i_data(iClientWriteLast),      .o_data(oPM_WriteLast));
  npcg_pm_onehot_mux #(.W(1),  .N(N)) u_mux_wv   (.i_sel(r_owner), .i_data(iClientWriteValid),     .o_data(oPM_WriteValid));

endmodule

// File: tb/tb_npcg_toggle_pm_arbiter.sv
// Directed self-checking bench for npcg_toggle_pm_arbiter.
module tb_npcg_toggle_pm_arbiter;

  localparam int NW = 4;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0]    start, last, cas, wlast, wvalid, wready_o;
  logic [8*NC-1:0]  pcmd, cad;
  logic [3*NC-1:0]  popt;
  logic [NW*NC-1:0] way;
  logic [16*NC-1:0] nod;
  logic [32*NC-1:0] wdata;
  logic             pm_wready;
  logic [7:0]  o_pcmd, o_cad;
  logic [2:0]  o_popt;
  logic [NW-1:0] o_way;
  logic [15:0] o_nod, o_cnt;
  logic        o_cas, o_wlast, o_wvalid, o_allow, o_coll;
  logic [31:0] o_wdata;
  logic [NC-1:0] o_owner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  npcg_toggle_pm_arbiter #(.NumberOfWays(NW), .NumberOfClients(NC)) dut (
    .iSystemClock(clk), .iReset(rst),
    .iClientStart(start), .iClientLastStep(last),
    .iClientPCommand(pcmd), .iClientPCommandOption(popt),
    .iClientTargetWay(way), .iClientNumOfData(nod),
    .iClientCASelect(cas), .iClientCAData(cad),
    .iClientWriteData(wdata), .iClientWriteLast(wlast), .iClientWriteValid(wvalid),
    .oClientWriteReady(wready_o),
    .oPM_PCommand(o_pcmd), .oPM_PCommandOption(o_popt), .oPM_TargetWay(o_way),
    .oPM_NumOfData(o_nod), .oPM_CASelect(o_cas), .oPM_CAData(o_cad),
    .oPM_WriteData(o_wdata), .oPM_WriteLast(o_wlast), .oPM_WriteValid(o_wvalid),
    .iPM_WriteReady(pm_wready),
    .oCMDAllow(o_allow), .oOwner(o_owner), .oCollision(o_coll), .oOpCount(o_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = '0; last = '0; pcmd = '0; popt = '0; way = '0; nod = '0;
    cas = '0; cad = '0; wdata = '0; wlast = '0; wvalid = '0; pm_wready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clr();
    do_reset();

    // Reset state, with ready high so any leak to a client would show.
    pm_wready = 1'b1;
    pcmd[0*8 +: 8] = 8'h5A;
    #1;
    chk("rst_owner", 32'(o_owner), 32'h0);
    chk("rst_coll",  32'(o_coll),  32'h0);
    chk("rst_cnt",   32'(o_cnt),   32'h0);
    chk("rst_allow", 32'(o_allow), 32'h1);
    chk("rst_pcmd",  32'(o_pcmd),  32'h0);
    chk("rst_wrdy",  32'(wready_o), 32'h0);
    clr();

    // Client 2 owns for 20 cycles.
    pcmd[2*8 +: 8] = 8'h08;
    nod[2*16 +: 16] = 16'd5;
    way[2*NW +: NW] = 4'b0100;
    start[2] = 1'b1;
    tick();
    start = '0;
    chk("c2_owner", 32'(o_owner), 32'h4);
    chk("c2_pcmd",  32'(o_pcmd),  32'h08);
    chk("c2_nod",   32'(o_nod),   32'd5);
    chk("c2_way",   32'(o_way),   32'h4);
    chk("c2_allow", 32'(o_allow), 32'h0);
    for (int i = 0; i < 19; i++) tick();
    last[2] = 1'b1;
    #1;
    chk("c2_last_allow", 32'(o_allow), 32'h1);
    chk("c2_last_pcmd",  32'(o_pcmd),  32'h08);
    tick();
    last = '0;
    chk("c2_rel_owner", 32'(o_owner), 32'h0);
    chk("c2_rel_cnt",   32'(o_cnt),   32'd1);
    chk("c2_rel_pcmd",  32'(o_pcmd),  32'h0);
    chk("c2_rel_coll",  32'(o_coll),  32'h0);
    clr();

    // Handover: owner 0 last step together with client 3 start.
    start[0] = 1'b1;
    tick();
    start = '0;
    chk("ho_owner0", 32'(o_owner), 32'h1);
    last[0] = 1'b1;
    start[3] = 1'b1;
    #1;
    chk("ho_allow", 32'(o_allow), 32'h1);
    tick();
    clr();
    chk("ho_owner3", 32'(o_owner), 32'h8);
    chk("ho_cnt",    32'(o_cnt),   32'd2);
    chk("ho_coll",   32'(o_coll),  32'h0);

    // Mid-operation start from another client is a collision.
    do_reset();
    chk("rst2_cnt", 32'(o_cnt), 32'h0);
    pcmd[0*8 +: 8] = 8'h11;
    pcmd[1*8 +: 8] = 8'h22;
    cad[0*8 +: 8]  = 8'hC0;
    cad[1*8 +: 8]  = 8'hC1;
    start[0] = 1'b1;
    tick();
    start = '0;
    start[1] = 1'b1;
    #1;
    chk("mid_allow", 32'(o_allow), 32'h0);
    tick();
    start = '0;
    chk("mid_owner", 32'(o_owner), 32'h1);
    chk("mid_coll",  32'(o_coll),  32'h1);
    chk("mid_pcmd",  32'(o_pcmd),  32'h11);
    chk("mid_cad",   32'(o_cad),   32'hC0);

    // Owner write burst of 4 words with toggling ready; client 1 drives noise.
    for (int k = 0; k < 4; k++) begin
      wdata[0*32 +: 32] = 32'hA000_0000 + 32'(k);
      wdata[1*32 +: 32] = 32'hDEAD_0000 + 32'(k);
      wvalid = 4'b0011;
      wlast[0] = (k == 3);
      wlast[1] = 1'b1;
      pm_wready = (k % 2 == 0);
      #1;
      chk("wr_data",  o_wdata,        32'hA000_0000 + 32'(k));
      chk("wr_valid", 32'(o_wvalid),  32'h1);
      chk("wr_last",  32'(o_wlast),   (k == 3) ? 32'h1 : 32'h0);
      chk("wr_ready", 32'(wready_o),  (k % 2 == 0) ? 32'h1 : 32'h0);
      tick();
    end
    wvalid = '0; wlast = '0; pm_wready = 1'b0;
    last[0] = 1'b1;
    tick();
    last = '0;
    chk("wr_rel_owner", 32'(o_owner), 32'h0);
    chk("wr_rel_cnt",   32'(o_cnt),   32'd1);
    clr();

    // Simultaneous starts from idle: lowest index wins, collision flagged.
    do_reset();
    start = 4'b1010;
    tick();
    start = '0;
    chk("sim_owner", 32'(o_owner), 32'h2);
    chk("sim_coll",  32'(o_coll),  32'h1);

    // Non-owner last step is ignored.
    last[0] = 1'b1;
    tick();
    last = '0;
    chk("nolast_owner", 32'(o_owner), 32'h2);
    chk("nolast_cnt",   32'(o_cnt),   32'h0);

    // Counter wrap via 65535 back-to-back handovers between clients 0 and 1.
    do_reset();
    start[0] = 1'b1;
    tick();
    start = '0;
    for (int n = 0; n < 65535; n++) begin
      last  = (n % 2 == 0) ? 4'b0001 : 4'b0010;
      start = (n % 2 == 0) ? 4'b0010 : 4'b0001;
      tick();
    end
    clr();
    chk("wrap_ffff",  32'(o_cnt),   32'hFFFF);
    chk("wrap_owner", 32'(o_owner), 32'h2);
    chk("wrap_coll",  32'(o_coll),  32'h0);
    last[1] = 1'b1;
    tick();
    last = '0;
    chk("wrap_zero",  32'(o_cnt),   32'h0);
    chk("wrap_idle",  32'(o_owner), 32'h0);

    // Reset mid-ownership drops the owner with no count taken.
    pcmd[2*8 +: 8] = 8'h08;
    start[2] = 1'b1;
    tick();
    start = '0;
    last[2] = 1'b1;
    tick();
    last = '0;
    chk("pre_rst_cnt", 32'(o_cnt), 32'd1);
    start[2] = 1'b1;
    tick();
    start = '0;
    chk("pre_rst_owner", 32'(o_owner), 32'h4);
    rst = 1'b1;
    last[2] = 1'b1;
    tick();
    rst = 1'b0;
    last = '0;
    chk("mr_owner", 32'(o_owner), 32'h0);
    chk("mr_pcmd",  32'(o_pcmd),  32'h0);
    chk("mr_cnt",   32'(o_cnt),   32'h0);
    chk("mr_allow", 32'(o_allow), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
